// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types, sizes and round-robin pick helper for the decoder-driven
// grant arbiter.
package decoder_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        RELEASE
    } arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit scanning ptr, ptr+1, ... with wrap. The scan runs from
    // the farthest offset down so the nearest hit is written last.
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [SEL_W-1:0] ptr);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface decoder_rr_arbiter_if;
    import decoder_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic             ena;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  sel, ena, grant, busy, timeout
    );

    modport slave (
        input  req, done,
        output sel, ena, grant, busy, timeout
    );

endinterface

// File: rtl/decoder_rr_arbiter_decoder3to8.sv
// Existing 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3to8 (
    input  logic [2:0] sel,
    input  logic       ena,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (ena) begin
            out[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of a single one-hot select resource: hold-time limit,
// break-before-make gap, and decoder-driven grant lines.
//
// state   | meaning
// IDLE    | no owner; pick next requester from ptr on any request
// OWN     | sel owns the grant; leave on done, withdrawal or hold expiry
// RELEASE | mandatory dead cycle with ena low before the next pick
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15   // legal 1..255
) (
    input logic                 clk,
    input logic                 rst,
    decoder_rr_arbiter_if.slave bus
);

    localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              ena_q, ena_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  grant_w;
    rr_pick_t          pick;
    logic              owner_req;
    logic              expired;

    always_comb begin
        pick       = rr_pick(bus.req, ptr_q);
        owner_req  = bus.req[sel_q];
        expired    = (hold_cnt_q == HOLD_LAST);

        state_d    = state_q;
        sel_d      = sel_q;
        ena_d      = ena_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    sel_d      = pick.idx;
                    ena_d      = 1'b1;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                if (bus.done || !owner_req || expired) begin
                    ena_d     = 1'b0;
                    ptr_d     = sel_q + SEL_W'(1);
                    state_d   = RELEASE;
                    // done or withdrawal in the expiry cycle wins over timeout
                    timeout_d = !bus.done && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RELEASE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                ena_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ena_q      <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ena_q      <= ena_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    decoder3to8 u_dec (
        .sel (sel_q),
        .ena (ena_q),
        .out (grant_w)
    );

    assign bus.sel     = sel_q;
    assign bus.ena     = ena_q;
    assign bus.grant   = grant_w;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with MAX_HOLD=4.
module tb_decoder_rr_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    decoder_rr_arbiter_if bus_if ();

    decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until ena rises (bounded); low counts ena-low samples seen.
    task automatic wait_grant(output int low);
        low = 0;
        while (!bus_if.ena && low < 20) begin
            low++;
            step();
        end
        expect_eq("grant_wait", 32'(bus_if.ena), 32'd1);
    endtask

    int low;
    int n_on;
    logic [7:0] onehot;
    logic [2:0] rr_exp [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd2; rr_exp[2] = 3'd7; rr_exp[3] = 3'd0;

        // Reset with all requests high
        rst = 1'b1;
        bus_if.req  = 8'hFF;
        bus_if.done = 1'b0;
        step();
        step();
        expect_eq("rst_ena",     32'(bus_if.ena),     32'd0);
        expect_eq("rst_grant",   32'(bus_if.grant),   32'h00);
        expect_eq("rst_sel",     32'(bus_if.sel),     32'd0);
        expect_eq("rst_busy",    32'(bus_if.busy),    32'd0);
        expect_eq("rst_timeout", 32'(bus_if.timeout), 32'd0);
        rst = 1'b0;
        bus_if.req = 8'h00;
        step();
        expect_eq("idle_ena", 32'(bus_if.ena), 32'd0);

        // Single request
        bus_if.req = 8'h04;
        step();
        expect_eq("single_sel",   32'(bus_if.sel),   32'd2);
        expect_eq("single_grant", 32'(bus_if.grant), 32'h04);
        expect_eq("single_busy",  32'(bus_if.busy),  32'd1);
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        bus_if.req  = 8'h00;
        expect_eq("single_rel_grant", 32'(bus_if.grant),   32'h00);
        expect_eq("single_rel_busy",  32'(bus_if.busy),    32'd1);
        expect_eq("single_rel_to",    32'(bus_if.timeout), 32'd0);
        expect_eq("single_ptr",       32'(dut.ptr_q),      32'd3);
        step();
        expect_eq("single_idle_busy", 32'(bus_if.busy), 32'd0);
        expect_eq("single_idle_ena",  32'(bus_if.ena),  32'd0);

        // Round robin from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.req = 8'b1000_0101;
        for (int k = 0; k < 4; k++) begin
            wait_grant(low);
            onehot = 8'h01 << rr_exp[k];
            expect_eq("rr_sel",   32'(bus_if.sel),   32'(rr_exp[k]));
            expect_eq("rr_grant", 32'(bus_if.grant), 32'(onehot));
            if (k > 0) expect_eq("rr_gap", 32'(low), 32'd2);
            step();
            bus_if.done = 1'b1;
            step();
            bus_if.done = 1'b0;
            expect_eq("rr_rel_to", 32'(bus_if.timeout), 32'd0);
        end
        bus_if.req = 8'h00;
        step();
        expect_eq("rr_ptr", 32'(dut.ptr_q), 32'd1);

        // Hold-limit expiry for a sole persistent requester
        bus_if.req = 8'h20;
        wait_grant(low);
        expect_eq("to_grant", 32'(bus_if.grant), 32'h20);
        n_on = 0;
        while (bus_if.ena && n_on < 20) begin
            n_on++;
            step();
        end
        expect_eq("to_hold_len", 32'(n_on),           32'd4);
        expect_eq("to_pulse",    32'(bus_if.timeout), 32'd1);
        expect_eq("to_rel_busy", 32'(bus_if.busy),    32'd1);
        step();
        expect_eq("to_pulse_end", 32'(bus_if.timeout), 32'd0);
        expect_eq("to_idle_busy", 32'(bus_if.busy),    32'd0);
        wait_grant(low);
        expect_eq("to_regrant", 32'(bus_if.sel), 32'd5);
        // done in the expiry cycle suppresses timeout
        step();
        step();
        step();
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        bus_if.req  = 8'h00;
        expect_eq("to_done_ena", 32'(bus_if.ena),     32'd0);
        expect_eq("to_done_to",  32'(bus_if.timeout), 32'd0);
        step();
        step();

        // Withdrawal by owner 3, next pick wraps to 0
        bus_if.req = 8'h08;
        wait_grant(low);
        expect_eq("wd_sel", 32'(bus_if.sel), 32'd3);
        bus_if.req = 8'h0B;
        step();
        expect_eq("wd_hold_ena", 32'(bus_if.ena), 32'd1);
        bus_if.req = 8'h03;
        step();
        expect_eq("wd_ena", 32'(bus_if.ena),     32'd0);
        expect_eq("wd_to",  32'(bus_if.timeout), 32'd0);
        expect_eq("wd_ptr", 32'(dut.ptr_q),      32'd4);
        wait_grant(low);
        expect_eq("wd_next", 32'(bus_if.sel), 32'd0);
        expect_eq("wd_gap",  32'(low),        32'd2);
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        bus_if.req  = 8'h00;
        step();

        // Reset in the middle of a grant
        bus_if.req = 8'h10;
        wait_grant(low);
        expect_eq("mr_grant", 32'(bus_if.grant), 32'h10);
        rst = 1'b1;
        bus_if.done = 1'b1;
        step();
        bus_if.done = 1'b0;
        expect_eq("mr_grant0", 32'(bus_if.grant), 32'h00);
        expect_eq("mr_busy",   32'(bus_if.busy),  32'd0);
        expect_eq("mr_sel",    32'(bus_if.sel),   32'd0);
        expect_eq("mr_ptr",    32'(dut.ptr_q),    32'd0);
        rst = 1'b0;
        bus_if.req = 8'h11;
        step();
        expect_eq("mr_regrant", 32'(bus_if.grant), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
